// File: rtl/counter_pkg.sv
// Shared constants for the nibble-sliced counter; COUNTER_BCD_EN switches slices to decimal digits.
package counter_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [NIBBLE_W-1:0] BIN_DIGIT_MAX = 4'hF;
    localparam logic [NIBBLE_W-1:0] BCD_DIGIT_MAX = 4'd9;

`ifdef COUNTER_BCD_EN
    localparam logic [NIBBLE_W-1:0] DIGIT_MAX = BCD_DIGIT_MAX;
`else
    localparam logic [NIBBLE_W-1:0] DIGIT_MAX = BIN_DIGIT_MAX;
`endif

    typedef logic [NIBBLE_W-1:0] digit_t;

endpackage

// File: rtl/counter_nibble.sv
// One 4-bit up/down digit slice with forced load/zero; the carry/borrow output enables the next slice.
// Latency: q updates one edge after ci/force; co is combinational. No backpressure.
// Digit range is 0..F, or 0..9 when COUNTER_BCD_EN is defined.
module counter_nibble
    import counter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ci,
    input  logic                up,
    input  logic                force_zero,
    input  logic [NIBBLE_W-1:0] force_val,
    input  logic                force_en,
    output logic [NIBBLE_W-1:0] q,
    output logic                co
);

    digit_t r_q;
    digit_t w_q_nxt;

    always_comb begin
        w_q_nxt = r_q;
        if (force_en) begin
            w_q_nxt = force_val;
        end else if (force_zero) begin
            w_q_nxt = '0;
        end else if (ci) begin
            if (up) begin
                w_q_nxt = (r_q >= DIGIT_MAX) ? '0 : r_q + 4'd1;
`ifdef COUNTER_BCD_EN
            // Out-of-range loaded digits settle at 9 on the way down.
            end else if (r_q > DIGIT_MAX) begin
                w_q_nxt = DIGIT_MAX;
`endif
            end else begin
                w_q_nxt = (r_q == '0) ? DIGIT_MAX : r_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign q  = r_q;
    assign co = up ? (r_q >= DIGIT_MAX) : (r_q == '0);

endmodule

// File: rtl/counter_cascade_16b.sv
// Cascaded up/down counter with load, programmable terminal value and wrap/overflow reporting.
// Latency: q, wrap, ovf one edge after ld/ce; rc combinational. No backpressure.
// COUNTER_BCD_EN selects packed-BCD slices and a 16'h9999 reset terminal value.
module counter_cascade_16b
    import counter_pkg::*;
#(
    parameter int                              NIBBLES = 4,
    parameter logic [NIBBLE_W*NIBBLES-1:0]     MAX_RST = {NIBBLES{DIGIT_MAX}}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        up,
    input  logic                        ld,
    input  logic [NIBBLE_W*NIBBLES-1:0] d,
    input  logic                        max_wr,
    input  logic [NIBBLE_W*NIBBLES-1:0] max_in,
    output logic [NIBBLE_W*NIBBLES-1:0] q,
    output logic                        rc,
    output logic                        wrap,
    output logic                        ovf
);

    localparam int W = NIBBLE_W * NIBBLES;

    logic [W-1:0]       r_max;
    logic               r_wrap;
    logic               r_ovf;

    logic [W-1:0]       w_q;
    logic [NIBBLES:0]   w_ci;
    logic [NIBBLES-1:0] w_co;
    logic               w_at_max;
    logic               w_wrap_evt;
    logic               w_force_en;
    logic               w_force_zero;
    logic [W-1:0]       w_force_val;

    // When counting down, the end of the carry chain is exactly ce & (q == 0).
    assign w_ci[0]      = ce;
    assign w_at_max     = (w_q >= r_max);
    assign rc           = (up & ce & w_at_max) | (~up & w_ci[NIBBLES]);
    assign w_wrap_evt   = rc & ~ld;

    assign w_force_zero = w_wrap_evt & up;
    assign w_force_en   = ld | (w_wrap_evt & ~up);
    assign w_force_val  = ld ? d : r_max;

    genvar g;
    generate
        for (g = 0; g < NIBBLES; g++) begin : g_slice
            counter_nibble u_nibble (
                .clk        (clk),
                .rst_n      (rst_n),
                .ci         (w_ci[g]),
                .up         (up),
                .force_zero (w_force_zero),
                .force_val  (w_force_val[g*NIBBLE_W +: NIBBLE_W]),
                .force_en   (w_force_en),
                .q          (w_q[g*NIBBLE_W +: NIBBLE_W]),
                .co         (w_co[g])
            );
            assign w_ci[g+1] = w_ci[g] & w_co[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_max <= MAX_RST;
        end else if (max_wr) begin
            r_max <= max_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (ld) begin
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_wrap_evt) begin
            r_wrap <= 1'b1;
            r_ovf  <= 1'b1;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign q    = w_q;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_counter_cascade_16b.sv
// Bench for counter_cascade_16b: reference model feeds a scoreboard queue, each scenario task checks inline.
module tb_counter_cascade_16b;

`ifdef COUNTER_BCD_EN
    localparam logic [15:0] MAX_RST = 16'h9999;
`else
    localparam logic [15:0] MAX_RST = 16'hFFFF;
`endif

    typedef struct {
        logic [15:0] q;
        logic        wrap;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n, ce, up, ld, max_wr;
    logic [15:0] d, max_in;
    logic [15:0] q;
    logic        rc, wrap, ovf;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        rc_obs, rc_exp;

    logic [15:0] m_q = '0, m_max = MAX_RST;
    logic        m_wrap = 1'b0, m_ovf = 1'b0;

    counter_cascade_16b dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .up(up), .ld(ld), .d(d),
        .max_wr(max_wr), .max_in(max_in), .q(q), .rc(rc), .wrap(wrap), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] m_inc(input logic [15:0] v);
`ifdef COUNTER_BCD_EN
        logic [15:0] r = v;
        logic        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
                else begin r[4*i +: 4] = r[4*i +: 4] + 4'd1; c = 1'b0; end
            end
        end
        return r;
`else
        return v + 16'd1;
`endif
    endfunction

    function automatic logic [15:0] m_dec(input logic [15:0] v);
`ifdef COUNTER_BCD_EN
        logic [15:0] r = v;
        logic        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else if (r[4*i +: 4] > 4'd9) begin r[4*i +: 4] = 4'd9; b = 1'b0; end
                else begin r[4*i +: 4] = r[4*i +: 4] - 4'd1; b = 1'b0; end
            end
        end
        return r;
`else
        return v - 16'd1;
`endif
    endfunction

    // Drives one cycle of inputs, samples rc before the edge, pushes the model's next state.
    task automatic drive(input logic rs, input logic c, input logic u, input logic l,
                         input logic [15:0] dv, input logic mw, input logic [15:0] mi);
        exp_t        e;
        logic [15:0] nmax;
        @(negedge clk);
        rst_n = rs; ce = c; up = u; ld = l; d = dv; max_wr = mw; max_in = mi;
        #1;
        rc_obs = rc;
        rc_exp = c & ((u & (m_q >= m_max)) | (~u & (m_q == 16'd0)));
        nmax = mw ? mi : m_max;
        if (!rs) begin
            m_q = '0; m_max = MAX_RST; m_wrap = 1'b0; m_ovf = 1'b0;
        end else begin
            if (l) begin
                m_q = dv; m_wrap = 1'b0; m_ovf = 1'b0;
            end else if (c) begin
                if (u) begin
                    if (m_q >= m_max) begin m_q = '0; m_wrap = 1'b1; m_ovf = 1'b1; end
                    else begin m_q = m_inc(m_q); m_wrap = 1'b0; end
                end else begin
                    if (m_q == 16'd0) begin m_q = m_max; m_wrap = 1'b1; m_ovf = 1'b1; end
                    else begin m_q = m_dec(m_q); m_wrap = 1'b0; end
                end
            end else begin
                m_wrap = 1'b0;
            end
            m_max = nmax;
        end
        e.q = m_q; e.wrap = m_wrap; e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 16'h0005);
            e = sb.pop_front(); n_checks++;
            if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf})
                $display("FAIL reset: q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", q, wrap, ovf, e.q, e.wrap, e.ovf);
            else n_pass++;
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            e = sb.pop_front(); n_checks++;
            if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf} || q !== 16'(i))
                $display("FAIL post_reset_count: q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", q, wrap, ovf, e.q, e.wrap, e.ovf);
            else n_pass++;
        end
        // Terminal value must be MAX_RST despite max_wr during reset.
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b1, 1'b0, 1'b1, 1'b1, MAX_RST - 16'd1, 1'b0, 16'h0);
            else        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            n_checks++;
            if (rc_obs !== rc_exp) $display("FAIL reset_max_rc: rc=%b, want %b", rc_obs, rc_exp);
            else n_pass++;
            e = sb.pop_front(); n_checks++;
            if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf})
                $display("FAIL reset_max: q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", q, wrap, ovf, e.q, e.wrap, e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_cascade();
        exp_t e;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h00FF, 1'b0, 16'h0);
        void'(sb.pop_front());
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        n_checks++;
        if (rc_obs !== 1'b0) $display("FAIL cascade_rc: rc=%b, want 0", rc_obs);
        else n_pass++;
        e = sb.pop_front(); n_checks++;
        if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf} || q !== 16'h0100)
            $display("FAIL cascade: q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", q, wrap, ovf, e.q, e.wrap, e.ovf);
        else n_pass++;
    endtask

    task automatic test_wrap_up();
        exp_t        e;
        logic [15:0] seq [7] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd1};
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 1'b1, 16'h0005);
        void'(sb.pop_front());
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            n_checks++;
            if (rc_obs !== rc_exp) $display("FAIL wrap_up_rc: step %0d rc=%b, want %b", i, rc_obs, rc_exp);
            else n_pass++;
            e = sb.pop_front(); n_checks++;
            if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf} || q !== seq[i])
                $display("FAIL wrap_up: step %0d q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", i, q, wrap, ovf, e.q, e.wrap, e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_down_overrange();
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0:       drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0);
                1:       drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0);
                2:       drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0009, 1'b0, 16'h0);
                3:       drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0);
                4:       drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0009, 1'b0, 16'h0);
                default: drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0);
            endcase
            n_checks++;
            if (rc_obs !== rc_exp) $display("FAIL down_rc: step %0d rc=%b, want %b", i, rc_obs, rc_exp);
            else n_pass++;
            e = sb.pop_front(); n_checks++;
            if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf})
                $display("FAIL down_overrange: step %0d q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", i, q, wrap, ovf, e.q, e.wrap, e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        exp_t e;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0003);
        void'(sb.pop_front());
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hABCD, 1'b0, 16'h0);
        e = sb.pop_front(); n_checks++;
        if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf} || ovf !== 1'b0)
            $display("FAIL ld_over_ce: q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", q, wrap, ovf, e.q, e.wrap, e.ovf);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b0, 16'h0);
            e = sb.pop_front(); n_checks++;
            if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf})
                $display("FAIL hold: cycle %0d q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", i, q, wrap, ovf, e.q, e.wrap, e.ovf);
            else n_pass++;
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h4321, 1'b1, 16'h0007);
        void'(sb.pop_front());
        drive(1'b1, 1'b0, 1'b1, 1'b1, MAX_RST - 16'd1, 1'b0, 16'h0);
        void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
            e = sb.pop_front(); n_checks++;
            if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf})
                $display("FAIL reset_over_max_wr: step %0d q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", i, q, wrap, ovf, e.q, e.wrap, e.ovf);
            else n_pass++;
        end
    endtask

`ifdef COUNTER_BCD_EN
    task automatic test_bcd();
        exp_t        e;
        logic [15:0] ldv [4] = '{16'h0199, 16'h1000, 16'h9999, 16'h000C};
        logic        dir [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] res [4] = '{16'h0200, 16'h0999, 16'h0000, 16'h0010};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, dir[i], 1'b1, ldv[i], 1'b0, 16'h0);
            void'(sb.pop_front());
            drive(1'b1, 1'b1, dir[i], 1'b0, 16'h0, 1'b0, 16'h0);
            e = sb.pop_front(); n_checks++;
            if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf} || q !== res[i])
                $display("FAIL bcd: case %0d q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", i, q, wrap, ovf, e.q, e.wrap, e.ovf);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 40)),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 48)));
            n_checks++;
            if (rc_obs !== rc_exp) $display("FAIL random_rc: cycle %0d rc=%b, want %b", i, rc_obs, rc_exp);
            else n_pass++;
            e = sb.pop_front(); n_checks++;
            if ({q, wrap, ovf} !== {e.q, e.wrap, e.ovf})
                $display("FAIL random: cycle %0d q=%h wrap=%b ovf=%b, want q=%h wrap=%b ovf=%b", i, q, wrap, ovf, e.q, e.wrap, e.ovf);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; up = 1'b1; ld = 1'b0; d = '0; max_wr = 1'b0; max_in = '0;
        test_reset();
`ifndef COUNTER_BCD_EN
        test_cascade();
`endif
        test_wrap_up();
        test_down_overrange();
        test_priority();
`ifdef COUNTER_BCD_EN
        test_bcd();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_cascade_16b.md
Name: counter_cascade_16b

Overview:
- Synchronous 16-bit up/down counter built from four chained 4-bit nibble slices; each slice's ripple carry enables the next.
- Sits directly downstream of the single 4-bit counter stage and generalises it with load, enable, direction, programmable terminal value and wrap reporting.
- Feeds display/scan logic (q) and further cascade stages (rc).

Parameters:
- NIBBLES, 4, number of 4-bit slices; q width = 4*NIBBLES; only 4 is verified.
- MAX_RST, 16'hFFFF, terminal value loaded into the internal max register at reset (16'h9999 when COUNTER_BCD_EN is defined).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ce  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- ld  input  1  parallel load strobe.
- d  input  16  load value.
- max_wr  input  1  write strobe for terminal value.
- max_in  input  16  new terminal value.
- q  output  16  current count.
- rc  output  1  combinational ripple carry: ce & ((up & q>=max) | (~up & q==0)).
- wrap  output  1  registered one-cycle pulse on the cycle after a wrap.
- ovf  output  1  sticky wrap flag.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). No asynchronous paths.
- Reset values (rst_n=0 at the edge): q=0, max=MAX_RST, wrap=0, ovf=0. Reset overrides ld, ce and max_wr in the same cycle.
- Priority at each edge: rst_n low > ld > ce. max_wr is independent and can coincide with any of them.
- max update: max_wr=1 gives max<=max_in. The new max affects comparisons from the next cycle on. The same-cycle count step uses the old max.
- ld=1: q<=d, ovf<=0, wrap<=0. ce is ignored that cycle. d greater than max is accepted.
- ce=1, up=1: if q>=max then q<=0, wrap<=1, ovf<=1; else q<=q+1.
- ce=1, up=0: if q==0 then q<=max, wrap<=1, ovf<=1; else q<=q-1. If q>max, q decrements normally until it reaches 0.
- ce=0 and ld=0: q holds; wrap<=0; ovf holds.
- Latency:
  - q reflects ld or ce one edge later.
  - wrap is high for exactly the one cycle after the wrapping edge.
  - rc is combinational, zero latency.
- Cascade: slice k steps only when ce and the carry/borrow from slices 0..k-1 are all true, i.e. all lower digits are at digit max (up) or 0 (down). The terminal-value override forces all slices to the wrap result in the same edge.
- Direction change mid-count takes effect at the next enabled edge. No extra state.

Optional Feature:
- Macro: COUNTER_BCD_EN.
- Defined: each slice counts decimally.
  - Up: 9 -> 0 with carry. Down: 0 -> 9 with borrow.
  - q is packed BCD (e.g. 16'h0199 + 1 = 16'h0200). Comparisons against max are unchanged, because packed-BCD ordering equals binary ordering.
  - Loaded digits >= 10: on up they go to 0 with carry; on down they go to 9.
  - MAX_RST default is 16'h9999.
- Undefined: pure binary slices (0..F), MAX_RST default 16'hFFFF.

Decomposition:
- Shared package counter_pkg:
  - NIBBLE_W=4
  - BIN_DIGIT_MAX=4'hF
  - BCD_DIGIT_MAX=4'd9
  - digit-max selection constant (depends on COUNTER_BCD_EN)
- Sub-module counter_nibble:
  - Inputs: ci (step enable), up, force_zero, force_val[3:0], force_en.
  - Outputs: q[3:0], co (digit at max when up, at 0 when down).
  - Instantiated NIBBLES times, with co ANDed into the next slice's ci.
- The top level holds the max register, the wrap/ovf flags and the compare logic.

Test Plan:
- Reset: hold rst_n=0 with ce=1, ld=1, d=16'h1234 for 3 cycles -> q=0, wrap=0, ovf=0, max=MAX_RST. Release -> q counts 1, 2, 3.
- Nibble cascade (binary): ld d=16'h00FF, then ce=1 up=1 -> q=16'h0100 after one edge. rc=0 throughout, since q < max.
- Terminal wrap up: max_wr max_in=16'h0005, ld d=0, ce=1 up=1 for 7 edges -> q: 1, 2, 3, 4, 5, 0, 1. rc=1 while q=5. wrap=1 only in the cycle q=0 first appears. ovf=1 afterwards.
- Down wrap and overrange:
  - max=16'h0005, ld d=0, up=0, ce=1 -> q=5, wrap pulse.
  - ld d=16'h0009, up=1 -> q=0 next edge (q>=max).
  - ld d=16'h0009, up=0 -> 8, 7, ...
- Priority and clears:
  - ld=1 and ce=1 together with d=16'hABCD -> q=16'hABCD, ovf cleared.
  - rst_n=0 with max_wr=1 -> max=MAX_RST.
  - ce=0 -> q holds for 10 cycles.
- BCD build (COUNTER_BCD_EN defined):
  - ld 16'h0199, up -> 16'h0200.
  - ld 16'h1000, down -> 16'h0999.
  - ld 16'h9999, up -> 16'h0000 with wrap=1.
  - ld 16'h000C, up -> 16'h0010.
